word_ram_responder: RTL and testbench



---
 rtl/word_ram_responder.sv | 115 +++++++++++
 tb/tb_word_ram_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/word_ram_responder.sv
// word_ram_responder: 16-bit word RAM responder for the memory controller's
// word port. It accepts one request per cycle, returns read data one cycle
// after acceptance, and keeps mem_out coherent with writes to the last read
// address, because the controller merges byte writes against mem_out.
// Optional feature macro: WORD_RAM_CLEAR_EN. When it is defined, the array is
// zero-filled by a sweep after reset before the first request is accepted.
module word_ram_responder #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_in,
    output logic              mem_ready,
    output logic              mem_valid,
    output logic [15:0]       mem_out
);
    localparam int DEPTH = 2 ** ADDR_W;

    // Storage array; it has no reset, so its contents survive rst_n.
    logic [15:0] ram [DEPTH];

    logic [ADDR_W-1:0] rd_addr;
    logic              accept;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    assign accept = mem_req && mem_ready;

`ifdef WORD_RAM_CLEAR_EN
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    logic [0:0]      state;
    logic [ADDR_W:0] sweep_cnt;
    logic            sweep_last;

    // The counter is one bit wider than the address, so stopping at DEPTH-1
    // guarantees a single pass through the array.
    assign sweep_last = (sweep_cnt == (ADDR_W+1)'(DEPTH - 1));

    // Sweep sequencing: walk every word once, then open for requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
            mem_ready <= 1'b0;
        end else if (state == CLEAR) begin
            if (sweep_last) begin
                state     <= IDLE;
                mem_ready <= 1'b1;
            end else begin
                sweep_cnt <= sweep_cnt + (ADDR_W+1)'(1);
            end
        end
    end

    // Write port mux: the sweep owns the port while clearing; requests cannot
    // be accepted then because mem_ready is still low.
    always_comb begin
        wr_en   = accept && mem_we;
        wr_addr = mem_addr;
        wr_data = mem_in;
        if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = sweep_cnt[ADDR_W-1:0];
            wr_data = 16'h0000;
        end
    end
`else
    // Without the sweep the responder is ready from the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= 1'b1;
        end
    end

    assign wr_en   = accept && mem_we;
    assign wr_addr = mem_addr;
    assign wr_data = mem_in;
`endif

    // Single write port of the array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    // Read response path: registered data, one-cycle valid pulse, and the
    // same-address write bypass that keeps mem_out coherent for merges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_out   <= 16'h0000;
            rd_addr   <= '0;
        end else begin
            mem_valid <= 1'b0;
            if (accept) begin
                if (!mem_we) begin
                    mem_valid <= 1'b1;
                    rd_addr   <= mem_addr;
                    mem_out   <= ram[mem_addr];
                end else if (mem_addr == rd_addr) begin
                    mem_out <= mem_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_word_ram_responder.sv
// Testbench for word_ram_responder (ADDR_W = 4). A reference model of the
// responder's rules is updated on every clock edge; read responses are queued
// as they are issued and a monitor on the falling edge pops and compares them.
// Works with or without WORD_RAM_CLEAR_EN defined.
module tb_word_ram_responder;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [15:0]       mem_in = '0;
    logic              mem_ready;
    logic              mem_valid;
    logic [15:0]       mem_out;

    word_ram_responder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_in    (mem_in),
        .mem_ready (mem_ready),
        .mem_valid (mem_valid),
        .mem_out   (mem_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          known;
        logic [15:0] data;
    } resp_t;

    // Reference model state
    logic [15:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_ready = 1'b0;
    bit          m_valid = 1'b0;
    logic [15:0] m_out = 16'h0000;
    bit          m_out_known = 1'b1;
    int          m_rd_addr = 0;
    int          m_edges = 0;
    resp_t       exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the responder's rules at each rising edge.
    always @(posedge clk) begin
        if (rst_n) begin
            bit ready_before;
            int a;
            ready_before = m_ready;
            m_valid = 1'b0;
            m_edges++;
`ifdef WORD_RAM_CLEAR_EN
            if (!m_ready) begin
                m_mem[m_edges-1]   = 16'h0000;
                m_known[m_edges-1] = 1'b1;
                if (m_edges == DEPTH) m_ready = 1'b1;
            end
`else
            m_ready = 1'b1;
`endif
            if (mem_req && ready_before) begin
                a = int'(mem_addr);
                if (mem_we) begin
                    m_mem[a]   = mem_in;
                    m_known[a] = 1'b1;
                    if (a == m_rd_addr) begin
                        m_out       = mem_in;
                        m_out_known = 1'b1;
                    end
                end else begin
                    resp_t r;
                    r.known = m_known[a];
                    r.data  = m_mem[a];
                    exp_q.push_back(r);
                    m_valid     = 1'b1;
                    m_rd_addr   = a;
                    m_out       = m_mem[a];
                    m_out_known = m_known[a];
                end
            end
        end
    end

    // Monitor: compares handshake outputs every cycle and pops the scoreboard
    // whenever the DUT presents read data.
    always @(negedge clk) begin
        check("mem_ready", {15'd0, mem_ready}, {15'd0, m_ready});
        check("mem_valid", {15'd0, mem_valid}, {15'd0, m_valid});
        if (m_out_known) check("mem_out_hold", mem_out, m_out);
        if (mem_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL resp_unexpected: got %h expected no response at %0t", mem_out, $time);
            end else begin
                resp_t r;
                r = exp_q.pop_front();
                if (r.known) check("resp_data", mem_out, r.data);
            end
        end
    end

    // Drive one cycle of inputs; they are sampled at the next rising edge.
    task automatic drive(input bit req, input bit we, input int addr, input logic [15:0] data);
        mem_req  = req;
        mem_we   = we;
        mem_addr = ADDR_W'(addr);
        mem_in   = data;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 16'h0000);
    endtask

    // Assert reset asynchronously between edges and check outputs clear at once.
    task automatic apply_reset();
        rst_n = 1'b0;
        m_ready = 1'b0;
        m_valid = 1'b0;
        m_out = 16'h0000;
        m_out_known = 1'b1;
        m_rd_addr = 0;
        m_edges = 0;
        exp_q.delete();
        #1;
        check("rst_ready", {15'd0, mem_ready}, 16'h0000);
        check("rst_valid", {15'd0, mem_valid}, 16'h0000);
        check("rst_out", mem_out, 16'h0000);
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < DEPTH + 4 && !m_ready; i++) idle(1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = 16'h0000;
            m_known[i] = 1'b0;
        end
        #12;
        apply_reset();

        // Ready gating: a write attempted before ready must be dropped.
        drive(1'b1, 1'b1, 2, 16'hFFFF);
        drive(1'b1, 1'b1, 2, 16'hFFFF);
        mem_req = 1'b0;
        wait_ready();

        // Sweep result: every word reads back as zero (when clearing is built in).
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, i, 16'h0000);
        idle(2);

        // Write/read
        drive(1'b1, 1'b1, 3, 16'hBEEF);
        drive(1'b1, 1'b1, 4, 16'h1234);
        drive(1'b1, 1'b0, 3, 16'h0000);
        idle(2);
        check("wr_rd_out", mem_out, 16'hBEEF);

        // Coherency
        drive(1'b1, 1'b1, 7, 16'h00AA);
        drive(1'b1, 1'b0, 7, 16'h0000);
        drive(1'b1, 1'b1, 7, 16'h55AA);
        check("coh_bypass", mem_out, 16'h55AA);
        drive(1'b1, 1'b1, 8, 16'h0001);
        check("coh_hold", mem_out, 16'h55AA);
        idle(1);

        // Reset mid-read, then recovery (the sweep restarts when built in).
        drive(1'b1, 1'b1, 5, 16'h5555);
        drive(1'b1, 1'b0, 5, 16'h0000);
        apply_reset();
        wait_ready();
`ifdef WORD_RAM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b1;
`endif

        // Streaming: fill, then 16 back-to-back reads.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, i, 16'(i) * 16'h0101);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, i, 16'h0000);
        idle(2);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, DEPTH - 1)), 16'($urandom));
        end
        idle(3);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL resp_missing: got %0d outstanding expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
